// File: rtl/pio_isr_if.sv
// ============================================================================
//  Module      : pio_isr_if
//  Description : Bundle of the SM-side control/data signals and the RX FIFO
//                write port seen by the PIO input shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pio_isr_if;
    logic        penable;
    logic        restart;
    logic        stalled;
    logic [31:0] din;
    logic [4:0]  shift;
    logic        dir;
    logic        set;
    logic        do_shift;
    logic        do_push;
    logic        push_iffull;
    logic        push_block;
    logic        autopush;
    logic [4:0]  push_thresh;
    logic        fifo_full;
    logic        fifo_wr;
    logic [31:0] fifo_wdata;
    logic        push_stall;
    logic        rx_drop;
    logic [31:0] dout;
    logic [5:0]  shift_count;

    // State machine / decoder side: drives requests, observes ISR results
    modport master (
        output penable, restart, stalled, din, shift, dir, set, do_shift,
               do_push, push_iffull, push_block, autopush, push_thresh,
               fifo_full,
        input  fifo_wr, fifo_wdata, push_stall, rx_drop, dout, shift_count
    );

    // ISR side
    modport slave (
        input  penable, restart, stalled, din, shift, dir, set, do_shift,
               do_push, push_iffull, push_block, autopush, push_thresh,
               fifo_full,
        output fifo_wr, fifo_wdata, push_stall, rx_drop, dout, shift_count
    );
endinterface

`default_nettype wire

// File: rtl/pio_isr.sv
// ============================================================================
//  Module      : pio_isr
//  Description : PIO state-machine input shift register with IN shifting,
//                autopush and PUSH (IfFull / Block) handling into the RX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_isr (
    input  wire logic  clk,
    input  wire logic  reset,
    pio_isr_if.slave   bus
);

    logic [31:0] isr_q, isr_d;
    logic [5:0]  count_q, count_d;

    logic [6:0]  w_n;          // IN bit count, 1..32
    logic [6:0]  w_th;         // push threshold, 1..32
    logic [6:0]  w_lsh;        // 32 - n, left shift that places din[n-1:0] at the top
    logic [31:0] w_din_mask;
    logic [31:0] w_isr_n;      // ISR contents after the IN shift
    logic [6:0]  w_cnt_sum;
    logic [6:0]  w_cnt_n;      // saturated count after the IN shift
    logic        w_act;        // outputs may be asserted this cycle
    logic        w_shift_op;   // IN wins arbitration
    logic        w_push_op;    // PUSH wins arbitration
    logic        w_auto_hit;   // IN reaches the autopush threshold
    logic        w_push_ok;    // PUSH is not suppressed by IfFull
    logic        w_push_stall;
    logic        w_fifo_wr;
    logic        w_rx_drop;
    logic        w_en;

    // Shift amount, threshold and shifted ISR value
    always_comb begin
        w_n        = (bus.shift == 5'd0)       ? 7'd32 : {2'b00, bus.shift};
        w_th       = (bus.push_thresh == 5'd0) ? 7'd32 : {2'b00, bus.push_thresh};
        w_lsh      = 7'd32 - w_n;
        w_din_mask = (w_n == 7'd32) ? 32'hFFFF_FFFF : ((32'd1 << w_n) - 32'd1);
        // A shift by 32 of a 32-bit operand yields zero, so n=32 reduces to din
        if (bus.dir)
            w_isr_n = (isr_q >> w_n) | (bus.din << w_lsh);
        else
            w_isr_n = (isr_q << w_n) | (bus.din & w_din_mask);
        w_cnt_sum  = {1'b0, count_q} + w_n;
        w_cnt_n    = (w_cnt_sum > 7'd32) ? 7'd32 : w_cnt_sum;
    end

    // Request decode and FIFO-side outputs; stall is built from request terms only
    always_comb begin
        w_act        = bus.penable & ~bus.stalled & ~reset & ~bus.restart;
        w_shift_op   = bus.do_shift & ~bus.set;
        w_push_op    = bus.do_push & ~bus.set & ~bus.do_shift;
        w_auto_hit   = w_shift_op & bus.autopush & (w_cnt_n >= w_th);
        w_push_ok    = w_push_op & ~(bus.push_iffull & ({1'b0, count_q} < w_th));
        w_push_stall = w_act & bus.fifo_full &
                       (w_auto_hit | (w_push_ok & bus.push_block));
        w_fifo_wr    = w_act & ~bus.fifo_full & (w_auto_hit | w_push_ok);
        w_rx_drop    = w_act & bus.fifo_full & w_push_ok & ~bus.push_block;
        w_en         = bus.penable & ~bus.stalled & ~w_push_stall;
    end

    // Next-state selection in priority order set > IN > PUSH
    always_comb begin
        isr_d   = isr_q;
        count_d = count_q;
        if (bus.set) begin
            isr_d   = bus.din;
            count_d = 6'd0;
        end else if (w_shift_op) begin
            if (w_auto_hit) begin
                // Stall case never reaches here because en is low then
                isr_d   = 32'd0;
                count_d = 6'd0;
            end else begin
                isr_d   = w_isr_n;
                count_d = w_cnt_n[5:0];
            end
        end else if (w_push_ok) begin
            // Covers both a successful write and a non-blocking drop
            isr_d   = 32'd0;
            count_d = 6'd0;
        end
    end

    // State registers: reset and restart clear regardless of the enable
    always_ff @(posedge clk) begin
        if (reset || bus.restart) begin
            isr_q   <= 32'd0;
            count_q <= 6'd0;
        end else if (w_en) begin
            isr_q   <= isr_d;
            count_q <= count_d;
        end
    end

    assign bus.fifo_wr     = w_fifo_wr;
    assign bus.fifo_wdata  = w_auto_hit ? w_isr_n : isr_q;
    assign bus.push_stall  = w_push_stall;
    assign bus.rx_drop     = w_rx_drop;
    assign bus.dout        = isr_q;
    assign bus.shift_count = count_q;

endmodule

`default_nettype wire
